vga_pixel_pipeline: RTL and testbench

Pixel-data stage that sits directly downstream of the VGA sync/timing generator. It consumes the generator's sync, active-video and pixel coordinates, and fetches a 160x120, 12-bit framebuffer pixel-doubled 4x to 640x480, or substitutes a test pattern. It drives the 4:4:4 RGB bus with sync outputs delayed to match. It also owns the framebuffer write port, arbitrating a single-port RAM between display reads and upstream writes.

---
 rtl/vga_pixel_pipeline.sv | 136 +++++++++++++
 tb/tb_vga_pixel_pipeline.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipeline.sv
// rtl/vga_pixel_pipeline.sv - framebuffer/test-pattern pixel stage with sync-aligned RGB output
// Display reads own the single-port RAM on active pix_en cycles; writes take every other cycle.
module vga_pixel_pipeline #(
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15
) (
   input  logic              clk_50,
   input  logic              rst_n,
   input  logic              pix_en,
   input  logic              in_hs,
   input  logic              in_vs,
   input  logic              in_active,
   input  logic [9:0]        in_x,
   input  logic [9:0]        in_y,
   input  logic [1:0]        pattern_sel,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [11:0]       wr_data,
   output logic [3:0]        VGA_BUS_R,
   output logic [3:0]        VGA_BUS_G,
   output logic [3:0]        VGA_BUS_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              err_oob
);
   localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(FB_W * FB_H);

   logic [11:0]       fb_mem [FB_W*FB_H];
   logic [11:0]       ram_rd_q;
   logic [1:0]        rst_sync_q;
   logic [ADDR_W-1:0] yq, xq, rd_addr;
   logic              rd_en, wr_fire, wr_inrange, vs_fall;

   logic              s0_hs_q, s0_vs_q, s0_act_q, s0_yb_q;
   logic [3:0]        s0_xb_q;
   logic              s1_hs_q, s1_vs_q, s1_act_q, s1_yb_q;
   logic [3:0]        s1_xb_q;
   logic [11:0]       s1_data_q;
   logic [11:0]       rgb_q, rgb_d;
   logic              hs_q, vs_q;
   logic [1:0]        mode_q;
   logic [11:0]       solid_q;
   logic              err_q;
   logic [2:0]        bar;

   // 160 = 128 + 32, so the row offset is two shifts and an add
   assign yq      = ADDR_W'(in_y >> SCALE_SHIFT);
   assign xq      = ADDR_W'(in_x >> SCALE_SHIFT);
   assign rd_addr = (yq << 7) + (yq << 5) + xq;

   assign rd_en      = pix_en & in_active;
   assign wr_ready   = rst_sync_q[1] & ~rd_en;
   assign wr_fire    = wr_valid & wr_ready;
   assign wr_inrange = wr_addr < FB_WORDS;
   assign vs_fall    = pix_en & s0_vs_q & ~in_vs;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   // Read data is captured on the strobe itself, so a later write to the same word never bypasses
   always_ff @(posedge clk_50) begin
      if (wr_fire && wr_inrange) fb_mem[wr_addr] <= wr_data;
      else if (rd_en)            ram_rd_q <= fb_mem[rd_addr];
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= 2'd0;
         solid_q <= 12'h000;
         err_q   <= 1'b0;
      end else begin
         if (vs_fall)                  mode_q  <= pattern_sel;
         if (wr_fire && wr_inrange)    solid_q <= wr_data;
         if (wr_fire && !wr_inrange)   err_q   <= 1'b1;
      end
   end

   always_comb begin
      rgb_d = 12'h000;
      bar   = s1_xb_q[3:1];
      if (s1_act_q) begin
         case (mode_q)
            2'd0:    rgb_d = s1_data_q;
            2'd1:    rgb_d = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            2'd2:    rgb_d = (s1_xb_q[0] ^ s1_yb_q) ? 12'hFFF : 12'h000;
            default: rgb_d = solid_q;
         endcase
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         s0_hs_q   <= 1'b1;
         s0_vs_q   <= 1'b1;
         s0_act_q  <= 1'b0;
         s0_xb_q   <= 4'd0;
         s0_yb_q   <= 1'b0;
         s1_hs_q   <= 1'b1;
         s1_vs_q   <= 1'b1;
         s1_act_q  <= 1'b0;
         s1_xb_q   <= 4'd0;
         s1_yb_q   <= 1'b0;
         s1_data_q <= 12'h000;
         rgb_q     <= 12'h000;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
      end else if (pix_en) begin
         s0_hs_q   <= in_hs;
         s0_vs_q   <= in_vs;
         s0_act_q  <= in_active;
         s0_xb_q   <= in_x[8:5];
         s0_yb_q   <= in_y[5];
         s1_hs_q   <= s0_hs_q;
         s1_vs_q   <= s0_vs_q;
         s1_act_q  <= s0_act_q;
         s1_xb_q   <= s0_xb_q;
         s1_yb_q   <= s0_yb_q;
         s1_data_q <= ram_rd_q;
         rgb_q     <= rgb_d;
         hs_q      <= s1_hs_q;
         vs_q      <= s1_vs_q;
      end
   end

   assign VGA_BUS_R = rgb_q[11:8];
   assign VGA_BUS_G = rgb_q[7:4];
   assign VGA_BUS_B = rgb_q[3:0];
   assign VGA_HS    = hs_q;
   assign VGA_VS    = vs_q;
   assign err_oob   = err_q;
endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// tb/tb_vga_pixel_pipeline.sv - scoreboard bench for vga_pixel_pipeline
module tb_vga_pixel_pipeline;
   logic        clk_50 = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en = 1'b0, in_hs = 1'b1, in_vs = 1'b1, in_active = 1'b0;
   logic [9:0]  in_x = '0, in_y = '0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [14:0] wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, err_oob;

   vga_pixel_pipeline dut (
      .clk_50(clk_50), .rst_n(rst_n), .pix_en(pix_en), .in_hs(in_hs), .in_vs(in_vs),
      .in_active(in_active), .in_x(in_x), .in_y(in_y), .pattern_sel(pattern_sel),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .VGA_BUS_R(vga_r), .VGA_BUS_G(vga_g), .VGA_BUS_B(vga_b),
      .VGA_HS(vga_hs), .VGA_VS(vga_vs), .err_oob(err_oob)
   );

   always #10 clk_50 = ~clk_50;

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [11:0] m_ram [0:19199];
   logic [1:0]  m_mode = 2'd0;
   logic [11:0] m_solid = 12'h000;
   bit          m_err = 1'b0;
   bit          m_prev_vs = 1'b1;
   int          rel_cnt = 0;
   bit          pe_phase = 1'b1;
   bit          rst_cmd = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [11:0] ref_colour(input logic [1:0] mode, input bit act, input int x,
                                              input int y, input logic [11:0] fb, input logic [11:0] solid);
      int bar;
      if (!act) return 12'h000;
      case (mode)
         2'd0: return fb;
         2'd1: begin
            bar = (x / 64) % 8;
            return {(bar >= 4) ? 4'hF : 4'h0, ((bar / 2) % 2 == 1) ? 4'hF : 4'h0,
                    (bar % 2 == 1) ? 4'hF : 4'h0};
         end
         2'd2: return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
         default: return solid;
      endcase
   endfunction

   task automatic push_reset_entries();
      exp_t r;
      r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
      sb_q.push_back(r);
      sb_q.push_back(r);
   endtask

   // One clk_50 cycle of stimulus; the model predicts handshake, RAM, mode and expected pixel
   task automatic cyc(input bit hs, input bit vs, input bit act, input int x, input int y,
                      input bit wv, input int wa, input logic [11:0] wd);
      bit   rdy;
      exp_t e;
      @(negedge clk_50);
      if (rst_cmd && !rst_n) begin
         rst_n = 1'b1;
         push_reset_entries();
      end
      pix_en = pe_phase; in_hs = hs; in_vs = vs; in_active = act;
      in_x = 10'(x); in_y = 10'(y);
      wr_valid = wv; wr_addr = 15'(wa); wr_data = wd;
      rdy = (rel_cnt >= 2) && !(pe_phase && act);
      #1;
      chk("wr_ready", wr_ready, rdy);
      if (pe_phase && rst_n) begin
         if (m_prev_vs && !vs) m_mode = pattern_sel;
         m_prev_vs = vs;
         e.rgb = ref_colour(m_mode, act, x, y, m_ram[(y / 4) * 160 + x / 4], m_solid);
         e.hs = hs; e.vs = vs;
         sb_q.push_back(e);
      end
      if (wv && rdy) begin
         if (wa < 19200) begin
            m_ram[wa] = wd;
            m_solid = wd;
         end else m_err = 1'b1;
      end
      if (rst_n && rel_cnt < 2) rel_cnt++;
      pe_phase = !pe_phase;
   endtask

   task automatic pix(input bit hs, input bit vs, input bit act, input int x, input int y,
                      input int wmode, input bit oob);
      for (int k = 0; k < 2; k++) begin
         bit wv;
         int wa;
         wv = (wmode == 2) || (wmode == 1 && $urandom_range(0, 1) == 1);
         wa = (oob && $urandom_range(0, 7) == 0) ? 19200 + $urandom_range(0, 13567)
                                                 : $urandom_range(0, 19199);
         cyc(hs, vs, act, x, y, wv, wa, 12'($urandom));
      end
   endtask

   task automatic wr_blank(input int wa, input logic [11:0] wd);
      cyc(1, 1, 0, 0, 0, 1, wa, wd);
      cyc(1, 1, 0, 0, 0, 0, 0, 12'h000);
   endtask

   task automatic run_line(input int y, input int wmode, input bit oob);
      int x;
      for (int i = 0; i < 24; i++) begin
         if (i < 4) x = i;
         else if (i >= 20) x = 636 + (i - 20);
         else x = $urandom_range(0, 639);
         pix(1, 1, 1, x, y, wmode, oob);
      end
      for (int k = 0; k < 8; k++) pix(!(k >= 2 && k < 5), 1, 0, 0, y, wmode, oob);
   endtask

   // pattern_sel changes halfway through; the new mode must wait for the next frame's vsync
   task automatic run_frame(input logic [1:0] next_sel, input int wmode, input bit oob);
      int wl;
      for (int k = 0; k < 16; k++) pix(1, !(k >= 4 && k < 8), 0, 0, 0, 1, oob);
      wl = (m_mode == 2'd3) ? 0 : wmode;
      for (int l = 0; l < 8; l++) begin
         if (l == 4) pattern_sel = next_sel;
         run_line((l == 0) ? 0 : $urandom_range(0, 479), wl, oob);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
      chk({tag, "_hs"}, vga_hs, 1'b1);
      chk({tag, "_vs"}, vga_vs, 1'b1);
      chk({tag, "_err_oob"}, err_oob, 1'b0);
      chk({tag, "_wr_ready"}, wr_ready, 1'b0);
   endtask

   always @(posedge clk_50) begin
      if (pix_en && rst_n) begin
         #1;
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got no expected entry, expected one queued (t=%0t)", $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rgb", {vga_r, vga_g, vga_b}, mon_e.rgb);
            chk("hs", vga_hs, mon_e.hs);
            chk("vs", vga_vs, mon_e.vs);
         end
         chk("err_oob", err_oob, m_err);
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) pix(1, 1, 0, 0, 0, 0, 0);
      chk_reset("reset_init");
      rst_cmd = 1'b1;
      for (int i = 0; i < 3; i++) pix(1, 1, 0, 0, 0, 0, 0);

      for (int a = 0; a < 19200; a++) cyc(1, 1, 0, 0, 0, 1, a, 12'($urandom));
      wr_blank(0, 12'hF00);
      wr_blank(159, 12'h0F0);
      wr_blank(19200, 12'h123);

      run_frame(2'd1, 1, 0);
      run_frame(2'd2, 2, 0);
      run_frame(2'd3, 1, 1);
      run_frame(2'd0, 1, 0);
      run_frame(2'd0, 2, 0);

      for (int x = 296; x <= 300; x++) pix(1, 1, 1, x, 40, 0, 0);
      @(posedge clk_50);
      #3;
      rst_n = 1'b0;
      rst_cmd = 1'b0;
      #1;
      chk_reset("reset_async");
      sb_q.delete();
      m_mode = 2'd0; m_solid = 12'h000; m_err = 1'b0; m_prev_vs = 1'b1; rel_cnt = 0;
      for (int i = 0; i < 2; i++) pix(1, 1, 1, 0, 0, 0, 0);
      chk_reset("reset_held");
      rst_cmd = 1'b1;
      pattern_sel = 2'd0;
      for (int x = 301; x < 306; x++) pix(1, 1, 1, x, 40, 0, 0);
      run_frame(2'd2, 1, 0);
      run_frame(2'd3, 1, 0);
      run_frame(2'd0, 0, 0);
      for (int i = 0; i < 4; i++) pix(1, 1, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
